// File: rtl/mult_div_unit_if.sv
// Operand/result bus between the multiply/divide engine and the shared ripple ALU.
// The engine is the master: it drives ALUctl/A/B and consumes result/carry combinationally.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  modport master (
    output alu_ctl, alu_a, alu_b,
    input  alu_result, alu_carry
  );

  modport slave (
    input  alu_ctl, alu_a, alu_b,
    output alu_result, alu_carry
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU engine producing HI/LO, one bit per cycle,
// borrowing the datapath ALU for every add/subtract step.
module mult_div_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     rs_val,
  input  logic [WIDTH-1:0]     rt_val,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  mult_div_unit_if.master      alu
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_shift;
  logic             w_div_ok;

  assign w_shift  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  // hi[31] set means the shifted remainder is a 33-bit value, always >= divisor
  assign w_div_ok = alu.alu_carry | r_hi[WIDTH-1];

  always_comb begin
    alu.alu_ctl = ALU_ADD;
    alu.alu_a   = '0;
    alu.alu_b   = '0;
    unique case (r_state)
      S_MUL: begin
        alu.alu_a = r_hi;
        alu.alu_b = r_lo[0] ? r_opnd : '0;
      end
      S_DIV: begin
        alu.alu_ctl = ALU_SUB;
        alu.alu_a   = w_shift;
        alu.alu_b   = r_opnd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_dbz   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            if (!op) begin
              r_hi    <= '0;
              r_lo    <= rt_val;
              r_opnd  <= rs_val;
              r_state <= S_MUL;
            end else if (rt_val != '0) begin
              r_hi    <= '0;
              r_lo    <= rs_val;
              r_opnd  <= rt_val;
              r_state <= S_DIV;
            end else begin
              r_hi    <= rs_val;
              r_lo    <= '1;
              r_opnd  <= rt_val;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          {r_hi, r_lo} <= {alu.alu_carry, alu.alu_result, r_lo[WIDTH-1:1]};
          r_count      <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_hi    <= w_div_ok ? alu.alu_result : w_shift;
          r_lo    <= {r_lo[WIDTH-2:0], w_div_ok};
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit with a behavioural 32-bit ripple ALU on the operand bus;
// vector table plus scoreboard of expected HI/LO/flags/latency.
module tb_mult_div_unit;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mult_div_unit_if #(.WIDTH(32)) alu_if ();

  mult_div_unit #(.WIDTH(32), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .alu         (alu_if)
  );

  // ALU32bit: ctl[2] selects inverted B with carry-in 1
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_if.alu_a}
            + {1'b0, (alu_if.alu_ctl[2] ? ~alu_if.alu_b : alu_if.alu_b)}
            + {32'd0, alu_if.alu_ctl[2]};
  end
  assign alu_if.alu_result = alu_sum[31:0];
  assign alu_if.alu_carry  = alu_sum[32];

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    logic [63:0] p;
    v.op = o; v.a = a; v.b = b; v.dbz = 1'b0; v.lat = 33;
    if (!o) begin
      p = {32'd0, a} * {32'd0, b};
      v.hi = p[63:32]; v.lo = p[31:0];
    end else if (b == 0) begin
      v.hi = a; v.lo = 32'hFFFF_FFFF; v.dbz = 1'b1; v.lat = 1;
    end else begin
      v.hi = a % b; v.lo = a / b;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] h, input logic [31:0] l, input logic z,
                              input int lt);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dbz = z; v.lat = lt;
    return v;
  endfunction

  task automatic check_idle_bus(input string tag);
    chk({tag, "_alu_ctl"}, {60'd0, alu_if.alu_ctl}, {60'd0, ALU_ADD});
    chk({tag, "_alu_ab"}, {alu_if.alu_a, alu_if.alu_b}, 64'd0);
  endtask

  // poke: hold start high (with junk operands) through MUL/DIV and the DONE cycle
  task automatic run_op(input vec_t v, input bit poke);
    vec_t e;
    int   lat;
    bit   busy_ok;
    @(negedge clk);
    start = 1'b1; op = v.op; rs_val = v.a; rt_val = v.b;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); rs_val = $urandom; rt_val = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && lat >= 5) start = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("hi", {32'd0, hi}, {32'd0, e.hi});
    chk("lo", {32'd0, lo}, {32'd0, e.lo});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
    chk("latency", 64'(lat), 64'(e.lat));
    chk("busy_during_op", {62'd0, busy_ok, busy}, 64'd3);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("hold_hi_lo", {hi, lo}, {e.hi, e.lo});
    check_idle_bus("idle");
  endtask

  initial begin
    bit saw_done;
    vecs.push_back(mk(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33));
    vecs.push_back(mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1));
    vecs.push_back(mk(1'b0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33));
    for (int unsigned i = 0; i < 6; i++)
      vecs.push_back(model(1'(i), $urandom, (i == 5) ? 32'd0 : $urandom));

    #12;
    chk("rst_hi_lo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    check_idle_bus("rst");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], 1'b0);
      if (vecs[i].dbz) begin
        repeat (3) @(posedge clk);
        #1 chk("dbz_held", {31'd0, div_by_zero, hi}, {31'd0, 1'b1, vecs[i].hi});
      end
    end

    // start pulses while busy and in DONE must not disturb the running op
    run_op(mk(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33), 1'b1);
    run_op(mk(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33), 1'b1);

    // asynchronous reset at iteration 10 of a MULTU
    @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_hi_lo", {hi, lo}, 64'd0);
    chk("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("no_done_after_abort", {63'd0, saw_done}, 64'd0);
    run_op(model(1'b0, 32'hDEAD_BEEF, 32'h0000_1001), 1'b0);
    run_op(model(1'b1, 32'hDEAD_BEEF, 32'h0000_1001), 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
